// File: rtl/irq_controller.sv
// Eight-source priority interrupt controller with a request/acknowledge handshake,
// bounded retries on a missing acknowledge, and a small memory-mapped config port.
module irq_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq_src,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        IACK,
  input  logic        eoi,
  output logic        I_Req,
  output logic [2:0]  irq_id,
  output logic        irq_active,
  output logic        irq_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_ACTIVE   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  src_dly_reg;
  logic [7:0]  enable_reg, enable_next;
  logic [7:0]  pending_reg, pending_next;
  logic [3:0]  retry_limit_reg, retry_limit_next;
  logic [3:0]  retry_cnt_reg, retry_cnt_next;
  logic [1:0]  wait_cnt_reg, wait_cnt_next;
  logic [2:0]  irq_id_reg, irq_id_next;
  logic        timeout_reg, timeout_next;

  logic [7:0]  src_rise;
  logic [7:0]  serviceable;
  logic [2:0]  lowest_idx;
  logic [7:0]  pend_wclr;
  logic [7:0]  ack_clr;
  logic        timeout_set;
  logic        unused_wdata_bits;

  assign unused_wdata_bits = ^cfg_wdata[31:8];

  assign src_rise    = irq_src & ~src_dly_reg;
  assign serviceable = pending_reg & enable_reg;
  assign pend_wclr   = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[7:0] : 8'd0;

  always_comb begin
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (serviceable[i]) lowest_idx = 3'(i);
    end
  end

  // A fresh edge beats any clear (software write or acknowledge) in the same cycle.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pending
      assign pending_next[gi] = src_rise[gi] |
                                (pending_reg[gi] & ~(pend_wclr[gi] | ack_clr[gi]));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    irq_id_next    = irq_id_reg;
    wait_cnt_next  = wait_cnt_reg;
    retry_cnt_next = retry_cnt_reg;
    timeout_set    = 1'b0;
    ack_clr        = 8'd0;
    case (state_reg)
      ST_IDLE: begin
        if (|serviceable) begin
          irq_id_next = lowest_idx;
          state_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        wait_cnt_next = 2'd0;
        state_next    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (IACK) begin
          ack_clr[irq_id_reg] = 1'b1;
          retry_cnt_next      = 4'd0;
          state_next          = ST_ACTIVE;
        end else if (wait_cnt_reg == 2'd3) begin
          if (retry_cnt_reg == retry_limit_reg) begin
            timeout_set    = 1'b1;
            retry_cnt_next = 4'd0;
            state_next     = ST_IDLE;
          end else begin
            retry_cnt_next = retry_cnt_reg + 4'd1;
            state_next     = ST_REQ;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 2'd1;
        end
      end
      ST_ACTIVE: begin
        if (eoi) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    enable_next      = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[7:0] : enable_reg;
    retry_limit_next = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata[3:0] : retry_limit_reg;
    timeout_next     = timeout_set | (timeout_reg & ~(cfg_we && cfg_addr == 2'd2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      src_dly_reg     <= 8'd0;
      enable_reg      <= 8'd0;
      pending_reg     <= 8'd0;
      retry_limit_reg <= 4'h3;
      retry_cnt_reg   <= 4'd0;
      wait_cnt_reg    <= 2'd0;
      irq_id_reg      <= 3'd0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      src_dly_reg     <= irq_src;
      enable_reg      <= enable_next;
      pending_reg     <= pending_next;
      retry_limit_reg <= retry_limit_next;
      retry_cnt_reg   <= retry_cnt_next;
      wait_cnt_reg    <= wait_cnt_next;
      irq_id_reg      <= irq_id_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign I_Req       = (state_reg == ST_REQ);
  assign irq_active  = (state_reg == ST_ACTIVE);
  assign irq_id      = irq_id_reg;
  assign irq_timeout = timeout_reg;

  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      2'd0: cfg_rdata = {24'd0, enable_reg};
      2'd1: cfg_rdata = {24'd0, pending_reg};
      2'd2: cfg_rdata = {27'd0, timeout_reg, irq_active, irq_id_reg};
      2'd3: cfg_rdata = {28'd0, retry_limit_reg};
      default: cfg_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios followed by a randomized
// run compared cycle by cycle against a sequence-timeline reference model.
module tb_irq_controller;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        IACK;
  logic        eoi;
  logic        I_Req;
  logic [2:0]  irq_id;
  logic        irq_active;
  logic        irq_timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: an in-flight request is a timeline t = 0,1,2,...; a request
  // pulse is issued whenever t is a multiple of 5, and t/5 is the attempt number.
  logic [7:0] m_pending, m_enable, m_prev;
  logic [3:0] m_limit;
  logic       m_timeout, m_busy, m_active;
  logic [2:0] m_id;
  int         m_t;

  irq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .IACK       (IACK),
    .eoi        (eoi),
    .I_Req      (I_Req),
    .irq_id     (irq_id),
    .irq_active (irq_active),
    .irq_timeout(irq_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = 32'd0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_src = 8'd0; IACK = 1'b0; eoi = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_pending = 8'd0; m_enable = 8'd0; m_prev = 8'd0; m_limit = 4'h3;
    m_timeout = 1'b0; m_busy = 1'b0; m_active = 1'b0; m_id = 3'd0; m_t = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_regs [4];
    exp_regs = '{32'h0, 32'h0, 32'h0, 32'h3};
    do_reset();
    cfg_write(2'd0, 32'hFF);
    cfg_write(2'd3, 32'h5);
    irq_src = 8'h11;
    tick();
    tick();
    // DUT sits in REQ here; reset must take effect without waiting for a clock edge
    reset = 1'b1;
    #1;
    checks++;
    if ({I_Req, irq_id, irq_active, irq_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {I_Req, irq_id, irq_active, irq_timeout}, 6'b0);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), d);
      checks++;
      if (d !== exp_regs[a]) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=%h", a, d, exp_regs[a]);
      end
    end
    tick();
    irq_src = 8'd0;
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_priority_eoi();
    logic [31:0] d;
    do_reset();
    cfg_write(2'd0, 32'hFF);
    irq_src = 8'h24;
    tick();
    tick();
    checks++;
    if (I_Req !== 1'b1 || irq_id !== 3'd2) begin
      failures++;
      $display("FAIL prio_req got I_Req=%b id=%0d exp I_Req=1 id=2", I_Req, irq_id);
    end
    IACK = 1'b1;
    tick();
    checks++;
    if (I_Req !== 1'b0) begin
      failures++;
      $display("FAIL prio_single_pulse got I_Req=%b exp=0", I_Req);
    end
    tick();
    IACK = 1'b0;
    cfg_read(2'd1, d);
    checks++;
    if (irq_active !== 1'b1 || d !== 32'h20) begin
      failures++;
      $display("FAIL prio_active got active=%b pending=%h exp active=1 pending=20", irq_active, d);
    end
    tick();
    checks++;
    if (I_Req !== 1'b0 || irq_active !== 1'b1) begin
      failures++;
      $display("FAIL no_nesting got I_Req=%b active=%b exp I_Req=0 active=1", I_Req, irq_active);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checks++;
    if (irq_active !== 1'b0 || I_Req !== 1'b0) begin
      failures++;
      $display("FAIL eoi_idle got active=%b I_Req=%b exp 0 0", irq_active, I_Req);
    end
    tick();
    checks++;
    if (I_Req !== 1'b1 || irq_id !== 3'd5) begin
      failures++;
      $display("FAIL eoi_next_req got I_Req=%b id=%0d exp I_Req=1 id=5", I_Req, irq_id);
    end
    $display("test_priority_eoi done");
  endtask

  task automatic test_retry_timeout();
    logic [31:0] d;
    int lims [2];
    int pulses;
    lims = '{2, 0};
    for (int li = 0; li < 2; li++) begin
      do_reset();
      cfg_write(2'd3, 32'(lims[li]));
      cfg_write(2'd0, 32'h08);
      irq_src = 8'h08;
      tick();
      tick();
      pulses = 0;
      for (int k = 0; k < 5 * (lims[li] + 1); k++) begin
        checks++;
        if (I_Req !== (k % 5 == 0)) begin
          failures++;
          $display("FAIL retry_pulse lim=%0d k=%0d got=%b exp=%b", lims[li], k, I_Req, (k % 5 == 0));
        end
        if (I_Req === 1'b1) pulses++;
        tick();
      end
      cfg_read(2'd2, d);
      checks++;
      if (d !== 32'h13 || I_Req !== 1'b0 || pulses != lims[li] + 1) begin
        failures++;
        $display("FAIL timeout lim=%0d got status=%h I_Req=%b pulses=%0d exp status=13 I_Req=0 pulses=%0d",
                 lims[li], d, I_Req, pulses, lims[li] + 1);
      end
      cfg_read(2'd1, d);
      checks++;
      if (d !== 32'h08) begin
        failures++;
        $display("FAIL timeout_keep_pending got=%h exp=08", d);
      end
      cfg_write(2'd2, 32'h0);
      checks++;
      if (irq_timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_clear got=%b exp=0", irq_timeout);
      end
    end
    $display("test_retry_timeout done");
  endtask

  task automatic test_enable_gate();
    logic [31:0] d;
    do_reset();
    irq_src = 8'h80;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (I_Req !== 1'b0) begin
        failures++;
        $display("FAIL gated_no_req k=%0d got=%b exp=0", k, I_Req);
      end
    end
    cfg_read(2'd1, d);
    checks++;
    if (d !== 32'h80) begin
      failures++;
      $display("FAIL gated_pending got=%h exp=80", d);
    end
    cfg_write(2'd0, 32'h80);
    tick();
    checks++;
    if (I_Req !== 1'b1 || irq_id !== 3'd7) begin
      failures++;
      $display("FAIL enable_req got I_Req=%b id=%0d exp I_Req=1 id=7", I_Req, irq_id);
    end
    $display("test_enable_gate done");
  endtask

  task automatic test_reset_midseq();
    logic [31:0] d;
    do_reset();
    cfg_write(2'd0, 32'hFF);
    cfg_write(2'd3, 32'h7);
    irq_src = 8'h40;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    cfg_read(2'd0, d);
    checks++;
    if ({I_Req, irq_id, irq_active, irq_timeout} !== 6'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL midseq_reset got outs=%b enable=%h exp outs=0 enable=0",
               {I_Req, irq_id, irq_active, irq_timeout}, d);
    end
    cfg_read(2'd3, d);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL midseq_retry_limit got=%h exp=3", d);
    end
    tick();
    irq_src = 8'd0;
    reset = 1'b0;
    IACK = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (irq_active !== 1'b0 || I_Req !== 1'b0) begin
        failures++;
        $display("FAIL late_iack k=%0d got active=%b I_Req=%b exp 0 0", k, irq_active, I_Req);
      end
    end
    IACK = 1'b0;
    $display("test_reset_midseq done");
  endtask

  task automatic test_reset_edge();
    logic [31:0] d;
    irq_src = 8'h01;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    cfg_read(2'd1, d);
    checks++;
    if (d !== 32'h01) begin
      failures++;
      $display("FAIL high_at_reset_edge got=%h exp=01", d);
    end
    irq_src = 8'd0;
    $display("test_reset_edge done");
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    do_reset();
    tick();
    irq_src = 8'h04;
    cfg_write(2'd1, 32'h04);
    cfg_read(2'd1, d);
    checks++;
    if (d !== 32'h04) begin
      failures++;
      $display("FAIL set_wins got=%h exp=04", d);
    end
    cfg_write(2'd1, 32'h04);
    cfg_read(2'd1, d);
    checks++;
    if (d !== 32'h00) begin
      failures++;
      $display("FAIL w1c_clear got=%h exp=00", d);
    end
    $display("test_set_wins done");
  endtask

  task automatic test_random();
    logic [7:0]  rise, ackmask, wclr, sv;
    logic [31:0] exp_rd;
    logic        exp_ireq, tset;
    int          ph;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_ireq = m_busy && (m_t % 5 == 0);
      checks++;
      if ({I_Req, irq_id, irq_active, irq_timeout} !== {exp_ireq, m_id, m_active, m_timeout}) begin
        failures++;
        $display("FAIL rand_outputs cyc=%0d got={req,id,act,to}=%b exp=%b", cyc,
                 {I_Req, irq_id, irq_active, irq_timeout}, {exp_ireq, m_id, m_active, m_timeout});
      end
      if (cyc == 1500) begin
        reset = 1'b1;
        cfg_we = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        continue;
      end
      irq_src   = irq_src ^ 8'($urandom & $urandom & $urandom);
      IACK      = ($urandom_range(0, 3) == 0);
      eoi       = ($urandom_range(0, 4) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_we    = ($urandom_range(0, 7) == 0) && !(cfg_addr == 2'd3 && m_busy);
      cfg_wdata = $urandom;
      if (cfg_addr == 2'd3) cfg_wdata[3:0] = 4'($urandom_range(0, 3));
      #1;
      case (cfg_addr)
        2'd0:    exp_rd = {24'd0, m_enable};
        2'd1:    exp_rd = {24'd0, m_pending};
        2'd2:    exp_rd = {27'd0, m_timeout, m_active, m_id};
        default: exp_rd = {28'd0, m_limit};
      endcase
      checks++;
      if (cfg_rdata !== exp_rd) begin
        failures++;
        $display("FAIL rand_rdata cyc=%0d addr=%0d got=%h exp=%h", cyc, cfg_addr, cfg_rdata, exp_rd);
      end
      // advance the model by one clock using the inputs now applied
      rise    = irq_src & ~m_prev;
      m_prev  = irq_src;
      ackmask = 8'd0;
      tset    = 1'b0;
      sv      = m_pending & m_enable;
      if (m_active) begin
        if (eoi) m_active = 1'b0;
      end else if (m_busy) begin
        ph = m_t % 5;
        if (ph != 0 && IACK) begin
          m_active = 1'b1;
          m_busy = 1'b0;
          ackmask[m_id] = 1'b1;
        end else if (ph == 4 && (m_t / 5) == int'(m_limit)) begin
          tset = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_t++;
        end
      end else if (sv != 8'd0) begin
        for (int i = 7; i >= 0; i--) if (sv[i]) m_id = 3'(i);
        m_busy = 1'b1;
        m_t = 0;
      end
      wclr      = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[7:0] : 8'd0;
      m_pending = (m_pending & ~(wclr | ackmask)) | rise;
      if (cfg_we && cfg_addr == 2'd0) m_enable = cfg_wdata[7:0];
      if (cfg_we && cfg_addr == 2'd3) m_limit = cfg_wdata[3:0];
      m_timeout = tset | (m_timeout & !(cfg_we && cfg_addr == 2'd2));
      tick();
    end
    cfg_we = 1'b0;
    IACK = 1'b0;
    eoi = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; irq_src = 8'd0; IACK = 1'b0; eoi = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    test_reset();
    test_priority_eoi();
    test_retry_timeout();
    test_enable_gate();
    test_reset_midseq();
    test_reset_edge();
    test_set_wins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- irq_src  in  8  interrupt sources; bit 0 is highest priority.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  register select.
- cfg_wdata  in  32  config write data.
- cfg_rdata  out  32  config read data, combinational from cfg_addr.
- IACK  in  1  core acknowledge; registered copy of I_Req, held while the core stalls.
- eoi  in  1  end-of-interrupt pulse from software.
- I_Req  out  1  interrupt request pulse to the core.
- irq_id  out  3  ID of the interrupt being requested or serviced.
- irq_active  out  1  high while an interrupt is in service.
- irq_timeout  out  1  sticky flag set when retries are exhausted.

REQ-002 The register map SHALL be:
- 0 ENABLE[7:0], read/write.
- 1 PENDING[7:0]; a write of 1 clears that bit.
- 2 STATUS = {irq_timeout, irq_active, irq_id} in bits [4:0]; a write of any value clears irq_timeout.
- 3 RETRY_LIMIT[3:0], read/write.
Unused bits SHALL read 0.

Function
REQ-003 Each PENDING bit SHALL set on a rising edge of its irq_src bit, detected against a 1-cycle-delayed copy, in every FSM state.
REQ-004 When set and clear hit the same PENDING bit in one cycle, set SHALL win.
REQ-005 The FSM SHALL have four states: IDLE, REQ, WAIT_ACK, ACTIVE.
REQ-006 IDLE: when (PENDING & ENABLE) != 0, the block SHALL latch the lowest set index into irq_id and move to REQ on the next edge.
REQ-007 REQ SHALL last exactly 1 cycle with I_Req=1, then move to WAIT_ACK with the wait counter at 0. I_Req SHALL be 0 in every other state.
REQ-008 WAIT_ACK: IACK=1 SHALL move to ACTIVE, clear PENDING[irq_id] (an edge arriving the same cycle wins per REQ-004) and zero the retry counter.
REQ-009 WAIT_ACK: if IACK is still 0 after 4 cycles, the block SHALL increment the 4-bit retry counter and return to REQ.
REQ-010 If the retry counter equals RETRY_LIMIT on that 4-cycle expiry, the block SHALL instead set irq_timeout, keep PENDING, and return to IDLE.
REQ-011 RETRY_LIMIT=0 SHALL mean no retry: the first expiry times out.
REQ-012 ACTIVE: irq_active=1; no new request SHALL issue (no nesting); eoi=1 SHALL move to IDLE on the next edge.
REQ-013 eoi outside ACTIVE SHALL be ignored.
REQ-014 irq_id SHALL hold its value from the latch in IDLE until the next latch.
REQ-015 Clearing ENABLE or PENDING for the latched ID during REQ or WAIT_ACK SHALL NOT abort the sequence. The sequence completes, and the acknowledge clears PENDING.
REQ-016 An IACK that arrives while in IDLE or ACTIVE SHALL be ignored.
REQ-017 A config write SHALL take effect on the clock edge. A read SHALL return the pre-edge value.

Reset
REQ-018 While reset=1 the block SHALL immediately force I_Req=0, irq_active=0, irq_timeout=0, irq_id=0, ENABLE=0, PENDING=0, RETRY_LIMIT=4'h3, the retry and wait counters to 0, the edge-detect copy to 0, and FSM=IDLE.
REQ-019 A reset asserted mid-sequence (REQ, WAIT_ACK or ACTIVE) SHALL drop I_Req within the same cycle and discard the in-flight interrupt.
REQ-020 After reset deassertion, the first edge capture SHALL compare against the zeroed copy, so a source already high registers as a rising edge.

Verification
REQ-021 ENABLE=0xFF; irq_src rises on bits 5 and 2 in the same cycle; IACK=1 one cycle after I_Req -> irq_id=2, one I_Req pulse, then irq_active=1 and PENDING=0x20.
REQ-022 eoi pulse in ACTIVE with PENDING=0x20 -> IDLE, then the next I_Req issues with irq_id=5.
REQ-023 RETRY_LIMIT=2 and IACK held 0 -> exactly 3 I_Req pulses spaced 5 cycles apart, then irq_timeout=1, PENDING bit retained, FSM back in IDLE.
REQ-024 ENABLE=0x00 with bit 7 pending -> no I_Req. Writing ENABLE=0x80 -> I_Req with irq_id=7 within 2 cycles.
REQ-025 Reset asserted during WAIT_ACK -> I_Req=0 and all registers at reset values immediately; a late IACK=1 after reset has no effect.
REQ-026 A PENDING write of 0x04 in the same cycle as a bit-2 rising edge -> PENDING[2]=1.
